// File: rtl/timer_cfg_sequencer_pkg.sv
// Shared register map, bit positions and state types for the timer configuration sequencer.
package timer_cfg_sequencer_pkg;

    // Timer IP register addresses on its APB slave port
    localparam logic [7:0] ADDR_TDR = 8'h00;
    localparam logic [7:0] ADDR_TCR = 8'h04;
    localparam logic [7:0] ADDR_TSR = 8'h08;

    // TCR bit positions
    localparam int TCR_LOAD_BIT = 7;
    localparam int TCR_EN_BIT   = 4;

    // TSR bit positions
    localparam int TSR_OVF_BIT = 0;
    localparam int TSR_UDF_BIT = 1;

    localparam logic [7:0] TSR_FLAGS = (8'h01 << TSR_OVF_BIT) | (8'h01 << TSR_UDF_BIT);

    // state         | meaning
    // ST_IDLE       | accepting commands, counting toward the next TSR poll
    // ST_WR_TDR     | writing the reload value into TDR
    // ST_WR_TCR_LD  | writing TCR with LOAD set (copies TDR into the counter)
    // ST_WR_TCR_RUN | writing TCR with LOAD clear (counter runs per EN)
    // ST_RD_TSR     | reading TSR to look for overflow/underflow flags
    // ST_WR_TSR_CLR | writing 0 to TSR to clear the flags just reported
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_TDR     = 3'd1,
        ST_WR_TCR_LD  = 3'd2,
        ST_WR_TCR_RUN = 3'd3,
        ST_RD_TSR     = 3'd4,
        ST_WR_TSR_CLR = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        XF_IDLE   = 2'd0,
        XF_SETUP  = 2'd1,
        XF_ACCESS = 2'd2
    } xfer_state_t;

    // Host TCR value with the LOAD bit overridden; the host's own bit 7 never reaches the timer.
    function automatic logic [7:0] tcr_with_load(input logic [7:0] tcr, input logic load);
        logic [7:0] r;
        r = tcr;
        r[TCR_LOAD_BIT] = load;
        return r;
    endfunction

endpackage

// File: rtl/timer_cfg_sequencer_xfer.sv
// Single APB transfer engine: SETUP then ACCESS until pready, aborted after TIMEOUT waits.
// A new start may be accepted in the completing ACCESS cycle so transfers chain with no gap.
module apb_xfer_engine
    import timer_cfg_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic       write,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic       timeout,
    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    output logic [7:0] paddr,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata,
    input  logic       pready
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    xfer_state_t   xst, xst_nxt;
    logic [TW-1:0] wait_cnt;
    logic [7:0]    addr_q;
    logic [7:0]    wdata_q;
    logic          write_q;

    // State register, captured transfer fields and the ACCESS wait down-counter
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            xst      <= XF_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
        end else begin
            xst <= xst_nxt;
            if (start) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                write_q <= write;
            end
            if (xst == XF_SETUP) begin
                wait_cnt <= TW'(TIMEOUT - 1);
            end else if (xst == XF_ACCESS && !pready && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    // Next transfer phase; terminal count in ACCESS without pready aborts
    always_comb begin
        xst_nxt = xst;
        case (xst)
            XF_IDLE:   if (start) xst_nxt = XF_SETUP;
            XF_SETUP:  xst_nxt = XF_ACCESS;
            XF_ACCESS: begin
                if (pready)              xst_nxt = start ? XF_SETUP : XF_IDLE;
                else if (wait_cnt == '0) xst_nxt = XF_IDLE;
            end
            default:   xst_nxt = XF_IDLE;
        endcase
    end

    assign done    = (xst == XF_ACCESS) && pready;
    assign timeout = (xst == XF_ACCESS) && !pready && (wait_cnt == '0);
    assign rdata   = prdata;
    assign psel    = (xst != XF_IDLE);
    assign penable = (xst == XF_ACCESS);
    assign pwrite  = write_q;
    assign paddr   = addr_q;
    assign pwdata  = wdata_q;

endmodule

// File: rtl/timer_cfg_sequencer.sv
// Sequences host commands into TDR/TCR writes and polls TSR for overflow/underflow events.
module timer_cfg_sequencer
    import timer_cfg_sequencer_pkg::*;
#(
    parameter int POLL_CYCLES = 16,
    parameter int TIMEOUT     = 32
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_load_val,
    input  logic [7:0] cmd_tcr,
    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    output logic [7:0] paddr,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata,
    input  logic       pready,
    output logic       busy,
    output logic       evt_ovf,
    output logic       evt_udf,
    output logic       err_timeout
);

    localparam bit POLL_EN   = (POLL_CYCLES > 0);
    localparam int POLL_LAST = (POLL_CYCLES > 0) ? POLL_CYCLES - 1 : 0;
    localparam int PW        = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    seq_state_t    state, state_nxt;
    logic [PW-1:0] poll_cnt;
    logic [7:0]    load_q;
    logic [7:0]    tcr_q;
    logic          accept;
    logic          flag_hit;
    logic          xf_start;
    logic [7:0]    xf_addr;
    logic          xf_write;
    logic [7:0]    xf_wdata;
    logic          xf_done;
    logic          xf_timeout;
    logic [7:0]    xf_rdata;

    apb_xfer_engine #(.TIMEOUT(TIMEOUT)) u_xfer (
        .pclk    (pclk),
        .presetn (presetn),
        .start   (xf_start),
        .addr    (xf_addr),
        .write   (xf_write),
        .wdata   (xf_wdata),
        .done    (xf_done),
        .rdata   (xf_rdata),
        .timeout (xf_timeout),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready)
    );

    // State, poll counter, latched command and the one-cycle event pulses
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state       <= ST_IDLE;
            poll_cnt    <= '0;
            load_q      <= '0;
            tcr_q       <= '0;
            evt_ovf     <= 1'b0;
            evt_udf     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            poll_cnt <= (state == ST_IDLE && state_nxt == ST_IDLE) ? poll_cnt + 1'b1 : '0;
            if (accept) begin
                load_q <= cmd_load_val;
                tcr_q  <= cmd_tcr;
            end
            evt_ovf     <= flag_hit & xf_rdata[TSR_OVF_BIT];
            evt_udf     <= flag_hit & xf_rdata[TSR_UDF_BIT];
            err_timeout <= xf_timeout;
        end
    end

    // Next state; each transfer is launched on the edge that enters its state
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        flag_hit  = 1'b0;
        xf_start  = 1'b0;
        xf_addr   = ADDR_TDR;
        xf_write  = 1'b1;
        xf_wdata  = 8'h00;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_WR_TDR;
                    xf_start  = 1'b1;
                    xf_wdata  = cmd_load_val;
                end else if (POLL_EN && poll_cnt == PW'(POLL_LAST)) begin
                    state_nxt = ST_RD_TSR;
                    xf_start  = 1'b1;
                    xf_addr   = ADDR_TSR;
                    xf_write  = 1'b0;
                end
            end
            ST_WR_TDR: begin
                if (xf_done) begin
                    state_nxt = ST_WR_TCR_LD;
                    xf_start  = 1'b1;
                    xf_addr   = ADDR_TCR;
                    xf_wdata  = tcr_with_load(tcr_q, 1'b1);
                end
            end
            ST_WR_TCR_LD: begin
                if (xf_done) begin
                    state_nxt = ST_WR_TCR_RUN;
                    xf_start  = 1'b1;
                    xf_addr   = ADDR_TCR;
                    xf_wdata  = tcr_with_load(tcr_q, 1'b0);
                end
            end
            ST_WR_TCR_RUN: begin
                if (xf_done) begin
                    state_nxt = ST_RD_TSR;
                    xf_start  = 1'b1;
                    xf_addr   = ADDR_TSR;
                    xf_write  = 1'b0;
                end
            end
            ST_RD_TSR: begin
                if (xf_done) begin
                    if ((xf_rdata & TSR_FLAGS) != 8'h00) begin
                        flag_hit  = 1'b1;
                        state_nxt = ST_WR_TSR_CLR;
                        xf_start  = 1'b1;
                        xf_addr   = ADDR_TSR;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_WR_TSR_CLR: begin
                if (xf_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // An abort discards the rest of the sequence
        if (xf_timeout) state_nxt = ST_IDLE;
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_timer_cfg_sequencer.sv
// Bench for timer_cfg_sequencer: APB slave model, transfer log and transaction-level reference.
module tb_timer_cfg_sequencer;
    import timer_cfg_sequencer_pkg::*;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } xfer_t;

    logic       pclk;
    logic       presetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_load_val;
    logic [7:0] cmd_tcr;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       busy;
    logic       evt_ovf;
    logic       evt_udf;
    logic       err_timeout;

    int errors = 0;
    int checks = 0;

    // slave model: pready policy chosen by the tests, TSR contents cleared by a TSR write
    int         pmode = 0;
    logic [7:0] tsr_val = 8'h00;
    int         tsr_gen = 0;
    int         clr_gen = 0;

    // monitor-owned observations
    xfer_t log_q[$];
    int    n_ovf = 0, n_udf = 0, n_err = 0, n_both = 0;
    int    proto_err = 0, pulse_err = 0;
    int    run = 0, last_stall = 0;

    xfer_t exp_q[$];

    assign prdata = (clr_gen == tsr_gen) ? 8'h00 : tsr_val;

    timer_cfg_sequencer #(.POLL_CYCLES(16), .TIMEOUT(32)) dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_load_val (cmd_load_val),
        .cmd_tcr      (cmd_tcr),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .pready       (pready),
        .busy         (busy),
        .evt_ovf      (evt_ovf),
        .evt_udf      (evt_udf),
        .err_timeout  (err_timeout)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

    // APB slave + monitor, evaluated mid-cycle
    initial begin
        logic       p_psel = 1'b0, p_pen = 1'b0, p_rdy = 1'b0, p_wr = 1'b0;
        logic [7:0] p_addr = 8'h00, p_wd = 8'h00;
        logic       p_ovf = 1'b0, p_udf = 1'b0, p_err = 1'b0;
        pready = 1'b1;
        forever begin
            @(negedge pclk);
            case (pmode)
                0:       pready = 1'b1;
                1:       pready = ($urandom_range(0, 3) != 0);
                2:       pready = 1'b0;
                default: pready = !(psel && paddr == ADDR_TCR && pwdata[TCR_LOAD_BIT]);
            endcase
            if (psel && penable) begin
                if (!p_psel || (p_pen && p_rdy) || paddr !== p_addr || pwrite !== p_wr || pwdata !== p_wd)
                    proto_err++;
                if (pready) begin
                    log_q.push_back({pwrite, paddr, pwrite ? pwdata : prdata});
                    if (pwrite && paddr == ADDR_TSR) clr_gen = tsr_gen;
                end else begin
                    run++;
                end
            end
            if (!(psel && penable && !pready) && run != 0) begin
                last_stall = run;
                run = 0;
            end
            if (evt_ovf && p_ovf) pulse_err++;
            if (evt_udf && p_udf) pulse_err++;
            if (err_timeout && p_err) pulse_err++;
            if (err_timeout && psel) pulse_err++;
            n_ovf  += int'(evt_ovf);
            n_udf  += int'(evt_udf);
            n_err  += int'(err_timeout);
            n_both += int'(evt_ovf && evt_udf);
            p_psel = psel; p_pen = penable; p_rdy = pready; p_wr = pwrite;
            p_addr = paddr; p_wd = pwdata;
            p_ovf = evt_ovf; p_udf = evt_udf; p_err = err_timeout;
        end
    end

    task automatic set_tsr(input logic [7:0] v);
        tsr_val = v;
        tsr_gen++;
    endtask

    // reference: the APB transactions one command should produce
    function automatic void model_cmd(input logic [7:0] ld, input logic [7:0] tcr, input logic [7:0] tsr);
        exp_q.delete();
        exp_q.push_back({1'b1, ADDR_TDR, ld});
        exp_q.push_back({1'b1, ADDR_TCR, tcr | 8'h80});
        exp_q.push_back({1'b1, ADDR_TCR, tcr & 8'h7F});
        exp_q.push_back({1'b0, ADDR_TSR, tsr});
        if (tsr[1:0] != 2'b00) exp_q.push_back({1'b1, ADDR_TSR, 8'h00});
    endfunction

    function automatic void model_poll(input logic [7:0] tsr);
        exp_q.delete();
        exp_q.push_back({1'b0, ADDR_TSR, tsr});
        if (tsr[1:0] != 2'b00) exp_q.push_back({1'b1, ADDR_TSR, 8'h00});
    endfunction

    function automatic bit log_ok(input int base);
        if (log_q.size() - base != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (log_q[base + i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string fmt_log(input int base);
        string s = "";
        for (int i = base; i < log_q.size() && i < base + 8; i++)
            s = {s, $sformatf(" %s%h=%h", log_q[i].wr ? "W" : "R", log_q[i].addr, log_q[i].data)};
        return s;
    endfunction

    function automatic string fmt_exp();
        string s = "";
        foreach (exp_q[i])
            s = {s, $sformatf(" %s%h=%h", exp_q[i].wr ? "W" : "R", exp_q[i].addr, exp_q[i].data)};
        return s;
    endfunction

    // Issues one command from a negedge; returns the log index before it and cycles to cmd_ready.
    task automatic do_cmd(input logic [7:0] ld, input logic [7:0] tcr, output int base, output int lat);
        int w = 0;
        while (!cmd_ready && w < 200) begin
            @(negedge pclk);
            w++;
        end
        base = log_q.size();
        cmd_load_val = ld;
        cmd_tcr      = tcr;
        cmd_valid    = 1'b1;
        @(negedge pclk);
        cmd_valid = 1'b0;
        lat = 0;
        while (!cmd_ready && lat < 300) begin
            @(negedge pclk);
            lat++;
        end
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        repeat (3) @(negedge pclk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL reset_psel_penable: got %b%b want 00", psel, penable); end
        checks++; if (pwrite !== 1'b0 || paddr !== 8'h00 || pwdata !== 8'h00) begin
            errors++; $display("FAIL reset_apb_fields: got pwrite=%b paddr=%h pwdata=%h want 0/00/00", pwrite, paddr, pwdata); end
        checks++; if ({evt_ovf, evt_udf, err_timeout} !== 3'b000) begin
            errors++; $display("FAIL reset_events: got %b%b%b want 000", evt_ovf, evt_udf, err_timeout); end
        presetn = 1'b1;
        @(negedge pclk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release_idle: got ready=%b busy=%b want 1/0", cmd_ready, busy); end
    endtask

    task automatic test_load_run();
        int base, lat, o0, u0;
        pmode = 0;
        set_tsr(8'h00);
        o0 = n_ovf; u0 = n_udf;
        model_cmd(8'hFF, 8'h01 << TCR_EN_BIT, 8'h00);
        do_cmd(8'hFF, 8'h01 << TCR_EN_BIT, base, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL load_run_latency: got %0d cycles want 8", lat); end
        checks++; if (!log_ok(base)) begin errors++; $display("FAIL load_run_log: got [%s] want [%s]", fmt_log(base), fmt_exp()); end
        checks++; if (n_ovf != o0 || n_udf != u0) begin
            errors++; $display("FAIL load_run_events: got ovf+%0d udf+%0d want 0/0", n_ovf - o0, n_udf - u0); end
    endtask

    task automatic test_no_false_event();
        int base, lat, o0, u0;
        pmode = 0;
        set_tsr(8'h00);
        o0 = n_ovf; u0 = n_udf;
        model_cmd(8'hFF, 8'h00, 8'h00);
        do_cmd(8'hFF, 8'h00, base, lat);
        checks++; if (!log_ok(base)) begin errors++; $display("FAIL ff_load_log: got [%s] want [%s]", fmt_log(base), fmt_exp()); end
        model_cmd(8'h00, 8'h00, 8'h00);
        do_cmd(8'h00, 8'h00, base, lat);
        checks++; if (!log_ok(base)) begin errors++; $display("FAIL zero_load_log: got [%s] want [%s]", fmt_log(base), fmt_exp()); end
        repeat (4) @(negedge pclk);
        checks++; if (n_ovf != o0 || n_udf != u0) begin
            errors++; $display("FAIL ff_then_00_events: got ovf+%0d udf+%0d want 0/0", n_ovf - o0, n_udf - u0); end
    endtask

    task automatic test_poll();
        int base, lat, n, w, o0, u0;
        pmode = 0;
        set_tsr(8'h00);
        do_cmd(8'($urandom), 8'($urandom), base, lat);
        set_tsr(8'h01);
        o0 = n_ovf; u0 = n_udf;
        base = log_q.size();
        n = 1;
        while (n < 100) begin
            @(negedge pclk);
            if (psel) break;
            n++;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL poll_interval: got %0d idle cycles want 16", n); end
        w = 0;
        while (!cmd_ready && w < 200) begin @(negedge pclk); w++; end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL poll_done: got ready=%b want 1", cmd_ready); end
        model_poll(8'h01);
        checks++; if (!log_ok(base)) begin errors++; $display("FAIL poll_log: got [%s] want [%s]", fmt_log(base), fmt_exp()); end
        checks++; if (n_ovf - o0 != 1 || n_udf != u0) begin
            errors++; $display("FAIL poll_events: got ovf+%0d udf+%0d want 1/0", n_ovf - o0, n_udf - u0); end
    endtask

    task automatic test_both_flags();
        int base, lat, o0, u0, b0;
        logic [7:0] ld, tcr;
        pmode = 0;
        ld = 8'($urandom); tcr = 8'($urandom);
        set_tsr(8'h03);
        o0 = n_ovf; u0 = n_udf; b0 = n_both;
        model_cmd(ld, tcr, 8'h03);
        do_cmd(ld, tcr, base, lat);
        checks++; if (!log_ok(base)) begin errors++; $display("FAIL both_flags_log: got [%s] want [%s]", fmt_log(base), fmt_exp()); end
        checks++; if (n_both - b0 != 1 || n_ovf - o0 != 1 || n_udf - u0 != 1) begin
            errors++; $display("FAIL both_flags_events: got both+%0d ovf+%0d udf+%0d want 1/1/1", n_both - b0, n_ovf - o0, n_udf - u0); end
    endtask

    task automatic test_timeout();
        int base, lat, e0;
        logic [7:0] ld;
        ld = 8'($urandom);
        set_tsr(8'h00);
        pmode = 3;
        e0 = n_err;
        exp_q.delete();
        exp_q.push_back({1'b1, ADDR_TDR, ld});
        do_cmd(ld, 8'h10, base, lat);
        pmode = 0;
        checks++; if (lat !== 35) begin errors++; $display("FAIL timeout_latency: got %0d cycles want 35", lat); end
        checks++; if (last_stall != 32) begin errors++; $display("FAIL timeout_access_cycles: got %0d want 32", last_stall); end
        checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL timeout_pulse: got %0d pulses want 1", n_err - e0); end
        checks++; if (!log_ok(base)) begin errors++; $display("FAIL timeout_log: got [%s] want [%s]", fmt_log(base), fmt_exp()); end
    endtask

    task automatic test_reset_mid();
        int base, lat, w;
        bit saw_psel;
        logic [7:0] ld, tcr;
        w = 0;
        while (!cmd_ready && w < 200) begin @(negedge pclk); w++; end
        pmode = 2;
        cmd_load_val = 8'h5A; cmd_tcr = 8'h10; cmd_valid = 1'b1;
        @(negedge pclk);
        cmd_valid = 1'b0;
        w = 0;
        while (!(penable && paddr == ADDR_TDR) && w < 20) begin @(negedge pclk); w++; end
        checks++; if (!(penable && paddr == ADDR_TDR)) begin
            errors++; $display("FAIL rst_mid_reach_access: got penable=%b paddr=%h want 1/%h", penable, paddr, ADDR_TDR); end
        presetn = 1'b0;
        @(negedge pclk);
        checks++; if (psel !== 1'b0 || penable !== 1'b0) begin
            errors++; $display("FAIL rst_mid_apb_drop: got psel=%b penable=%b want 0/0", psel, penable); end
        presetn = 1'b1;
        pmode = 0;
        set_tsr(8'h00);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", cmd_ready); end
        saw_psel = 1'b0;
        repeat (15) begin
            @(negedge pclk);
            if (psel) saw_psel = 1'b1;
        end
        checks++; if (saw_psel) begin errors++; $display("FAIL rst_mid_early_poll: got psel before expiry want none"); end
        ld = 8'($urandom); tcr = 8'($urandom);
        model_cmd(ld, tcr, 8'h00);
        do_cmd(ld, tcr, base, lat);
        checks++; if (!log_ok(base)) begin errors++; $display("FAIL cmd_beats_poll_log: got [%s] want [%s]", fmt_log(base), fmt_exp()); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL cmd_beats_poll_latency: got %0d cycles want 8", lat); end
    endtask

    task automatic test_random();
        int base, lat, o0, u0;
        logic [7:0] ld, tcr, tsr;
        pmode = 1;
        for (int i = 0; i < 10; i++) begin
            ld = 8'($urandom); tcr = 8'($urandom); tsr = 8'($urandom);
            set_tsr(tsr);
            o0 = n_ovf; u0 = n_udf;
            model_cmd(ld, tcr, tsr);
            do_cmd(ld, tcr, base, lat);
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rand_done[%0d]: got ready=%b want 1", i, cmd_ready); end
            checks++; if (!log_ok(base)) begin errors++; $display("FAIL rand_log[%0d]: got [%s] want [%s]", i, fmt_log(base), fmt_exp()); end
            checks++; if (n_ovf - o0 != int'(tsr[0]) || n_udf - u0 != int'(tsr[1])) begin
                errors++; $display("FAIL rand_events[%0d]: got ovf+%0d udf+%0d want %0d/%0d", i, n_ovf - o0, n_udf - u0, tsr[0], tsr[1]); end
        end
        pmode = 0;
    endtask

    task automatic test_protocol();
        repeat (4) @(negedge pclk);
        checks++; if (proto_err != 0) begin errors++; $display("FAIL apb_protocol: got %0d violations want 0", proto_err); end
        checks++; if (pulse_err != 0) begin errors++; $display("FAIL pulse_shape: got %0d bad pulses want 0", pulse_err); end
    endtask

    initial begin
        presetn      = 1'b0;
        cmd_valid    = 1'b0;
        cmd_load_val = 8'h00;
        cmd_tcr      = 8'h00;
        test_reset();
        test_load_run();
        test_no_false_event();
        test_poll();
        test_both_flags();
        test_timeout();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
